// File: rtl/bitblaster_param_core_if.sv
// rtl/bitblaster_param_core_if.sv - handshake, debug and status signal bundle for bitblaster_param_core
// Ports (signals):
//   instr/instr_valid/instr_ready : instruction offer and accept
//   ext_data/ext_valid/ext_ready  : external data for ld
//   peek_addr/peek_data           : second, combinational register read port
//   bus_o, timestep, done, err    : observation and completion/status
//   flag_z/flag_n/flag_c          : status flags (tied to 0 unless BB_STATUS_FLAGS_EN)
// Modports: master drives the core (sequencer/bench), slave is the core side.
interface bitblaster_param_core_if #(
    parameter int DW   = 10,
    parameter int NREG = 4
);
    localparam int RA = $clog2(NREG);

    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] ext_data;
    logic          ext_valid;
    logic          ext_ready;
    logic [RA-1:0] peek_addr;
    logic [DW-1:0] peek_data;
    logic [DW-1:0] bus_o;
    logic [1:0]    timestep;
    logic          done;
    logic          err;
    logic          flag_z;
    logic          flag_n;
    logic          flag_c;

    modport master (
        output instr, instr_valid, ext_data, ext_valid, peek_addr,
        input  instr_ready, ext_ready, peek_data, bus_o, timestep, done, err,
               flag_z, flag_n, flag_c
    );

    modport slave (
        input  instr, instr_valid, ext_data, ext_valid, peek_addr,
        output instr_ready, ext_ready, peek_data, bus_o, timestep, done, err,
               flag_z, flag_n, flag_c
    );
endinterface

// File: rtl/bitblaster_param_core.sv
// rtl/bitblaster_param_core.sv - parametrised multicycle Bitblaster core (FSM, IR, regfile, A/G ALU, ld path)
// Ports:
//   CLKb : clock, all state changes on the falling edge
//   CLR  : asynchronous active-high reset
//   bb   : bitblaster_param_core_if.slave (instruction/ext-data handshakes, peek port,
//          bus_o, timestep, done, err, flag_z/n/c)
// Optional feature macro: BB_STATUS_FLAGS_EN builds the z/n/c flag registers;
// without it the flag outputs are tied to 0.
module bitblaster_param_core #(
    parameter int DW   = 10,
    parameter int NREG = 4
) (
    input  logic                   CLKb,
    input  logic                   CLR,
    bitblaster_param_core_if.slave bb
);
    localparam int RA = $clog2(NREG);
    localparam int IW = DW - 2 - RA;
    localparam logic [DW:0] DW_L = (DW+1)'(DW);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_ir, r_a, r_g;
    logic [DW-1:0] r_regs [NREG];
    logic          r_done, r_err;

    // Instruction fields
    logic [1:0]    w_cls;
    logic [3:0]    w_fn;
    logic [RA-1:0] w_rx, w_ry;
    logic [DW-1:0] w_imm, w_rx_val, w_ry_val;
    logic          w_is_ld, w_is_cp, w_is_single, w_is_imm, w_illegal;

    assign w_cls       = r_ir[DW-1 -: 2];
    assign w_rx        = r_ir[DW-3 -: RA];
    assign w_ry        = r_ir[DW-3-RA -: RA];
    assign w_fn        = r_ir[3:0];
    assign w_imm       = {{(DW-IW){1'b0}}, r_ir[IW-1:0]};
    assign w_rx_val    = r_regs[w_rx];
    assign w_ry_val    = r_regs[w_ry];
    assign w_is_imm    = w_cls[1];
    assign w_is_ld     = (w_cls == 2'b00) && (w_fn == 4'h0);
    assign w_is_cp     = (w_cls == 2'b00) && (w_fn == 4'h1);
    assign w_is_single = (w_cls == 2'b00) && ((w_fn == 4'h4) || (w_fn == 4'h5));
    assign w_illegal   = (w_cls == 2'b01) || ((w_cls == 2'b00) && (w_fn >= 4'hC));

    // ALU: single-operand ops read Ry directly in T1, two-operand ops use A in T2.
    logic [DW-1:0] w_opa, w_opb, w_alu;
    logic [DW:0]   w_sum, w_dif;
    logic          w_big, w_carry;

    assign w_opa = w_is_single ? w_ry_val : r_a;
    assign w_opb = w_is_imm ? w_imm : w_ry_val;
    assign w_sum = {1'b0, w_opa} + {1'b0, w_opb};
    // c for subtraction is NOT borrow, i.e. the carry of A + ~B + 1
    assign w_dif = {1'b0, w_opa} + {1'b0, ~w_opb} + {{DW{1'b0}}, 1'b1};
    assign w_big = ({1'b0, w_opb} >= DW_L);

    always_comb begin
        w_alu   = '0;
        w_carry = 1'b0;
        if (w_is_imm) begin
            w_alu   = (w_cls == 2'b10) ? w_sum[DW-1:0] : w_dif[DW-1:0];
            w_carry = (w_cls == 2'b10) ? w_sum[DW]     : w_dif[DW];
        end else begin
            case (w_fn)
                4'h2: begin w_alu = w_sum[DW-1:0]; w_carry = w_sum[DW]; end
                4'h3: begin w_alu = w_dif[DW-1:0]; w_carry = w_dif[DW]; end
                4'h4: w_alu = '0 - w_opa;
                4'h5: w_alu = ~w_opa;
                4'h6: w_alu = w_opa & w_opb;
                4'h7: w_alu = w_opa | w_opb;
                4'h8: w_alu = w_opa ^ w_opb;
                4'h9: w_alu = w_big ? '0 : (w_opa << w_opb);
                4'hA: w_alu = w_big ? '0 : (w_opa >> w_opb);
                4'hB: w_alu = w_big ? {DW{w_opa[DW-1]}} : DW'($signed(w_opa) >>> w_opb);
                default: w_alu = '0;
            endcase
        end
    end

    // Controller
    logic          w_reg_we, w_a_we, w_g_we, w_fin, w_err_set;
    logic          w_instr_ready, w_ext_ready;
    logic [DW-1:0] w_reg_wdata, w_bus;

    always_ff @(negedge CLKb or posedge CLR) begin
        if (CLR) r_state <= T0;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_reg_we      = 1'b0;
        w_reg_wdata   = w_ry_val;
        w_a_we        = 1'b0;
        w_g_we        = 1'b0;
        w_fin         = 1'b0;
        w_err_set     = 1'b0;
        w_bus         = '0;
        w_instr_ready = 1'b0;
        w_ext_ready   = 1'b0;
        case (r_state)
            T0: begin
                w_instr_ready = 1'b1;
                if (bb.instr_valid) w_next = T1;
            end
            T1: begin
                if (w_illegal) begin
                    w_err_set = 1'b1;
                    w_fin     = 1'b1;
                    w_next    = T0;
                end else if (w_is_ld) begin
                    w_ext_ready = 1'b1;
                    w_bus       = bb.ext_data;
                    if (bb.ext_valid) begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = bb.ext_data;
                        w_fin       = 1'b1;
                        w_next      = T0;
                    end
                end else if (w_is_cp) begin
                    w_bus    = w_ry_val;
                    w_reg_we = 1'b1;
                    w_fin    = 1'b1;
                    w_next   = T0;
                end else if (w_is_single) begin
                    w_bus  = w_ry_val;
                    w_g_we = 1'b1;
                    w_next = T2;
                end else begin
                    w_bus  = w_rx_val;
                    w_a_we = 1'b1;
                    w_next = T2;
                end
            end
            T2: begin
                if (w_is_single) begin
                    w_bus       = r_g;
                    w_reg_we    = 1'b1;
                    w_reg_wdata = r_g;
                    w_fin       = 1'b1;
                    w_next      = T0;
                end else begin
                    w_bus  = w_opb;
                    w_g_we = 1'b1;
                    w_next = T3;
                end
            end
            T3: begin
                w_bus       = r_g;
                w_reg_we    = 1'b1;
                w_reg_wdata = r_g;
                w_fin       = 1'b1;
                w_next      = T0;
            end
            default: w_next = T0;
        endcase
    end

    // Datapath
    always_ff @(negedge CLKb or posedge CLR) begin
        if (CLR) begin
            r_ir   <= '0;
            r_a    <= '0;
            r_g    <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_done <= w_fin;
            if (w_err_set)                      r_err        <= 1'b1;
            if (w_instr_ready && bb.instr_valid) r_ir         <= bb.instr;
            if (w_a_we)                         r_a          <= w_rx_val;
            if (w_g_we)                         r_g          <= w_alu;
            if (w_reg_we)                       r_regs[w_rx] <= w_reg_wdata;
        end
    end

`ifdef BB_STATUS_FLAGS_EN
    logic r_fz, r_fn, r_fc;
    always_ff @(negedge CLKb or posedge CLR) begin
        if (CLR) begin
            r_fz <= 1'b0;
            r_fn <= 1'b0;
            r_fc <= 1'b0;
        end else if (w_g_we) begin
            r_fz <= (w_alu == '0);
            r_fn <= w_alu[DW-1];
            r_fc <= w_carry;
        end
    end
    assign bb.flag_z = r_fz;
    assign bb.flag_n = r_fn;
    assign bb.flag_c = r_fc;
`else
    assign bb.flag_z = 1'b0;
    assign bb.flag_n = 1'b0;
    assign bb.flag_c = 1'b0;
`endif

    assign bb.instr_ready = w_instr_ready;
    assign bb.ext_ready   = w_ext_ready;
    assign bb.peek_data   = r_regs[bb.peek_addr];
    assign bb.bus_o       = w_bus;
    assign bb.timestep    = r_state;
    assign bb.done        = r_done;
    assign bb.err         = r_err;
endmodule

// File: doc/bitblaster_param_core.md
Name: bitblaster_param_core

Overview:
Parametrised multicycle core that succeeds the fixed 10-bit Bitblaster datapath. Integrates the controller FSM, timestep tracking, instruction register, register file, A/G ALU staging and the external-data load path in one block. Data width and register count are parameters. Push-button strobes are replaced by valid/ready handshakes so the core can be fed by a sequencer, RAM or the board input logic.

Parameters:
DW, 10, data/instruction width; must satisfy DW >= 2 + 2*RA + 4.
NREG, 4, number of registers, power of 2, 2..16; RA = clog2(NREG).

Ports:
CLKb  in  1  clock; all state updates on falling edge.
CLR  in  1  asynchronous active-high reset.
instr  in  DW  instruction word.
instr_valid  in  1  instruction offered.
instr_ready  out  1  core accepts an instruction this cycle.
ext_data  in  DW  external data for ld.
ext_valid  in  1  ext_data valid.
ext_ready  out  1  core consumes ext_data this cycle.
peek_addr  in  RA  second read port address.
peek_data  out  DW  R[peek_addr], combinational.
bus_o  out  DW  value on the internal shared bus this cycle.
timestep  out  2  current timestep, T0..T3.
done  out  1  one-cycle completion pulse.
err  out  1  sticky illegal-instruction flag.

Behaviour:
- Instruction format, MSB first:
  - class [DW-1:DW-2]
  - Rx [DW-3 -: RA]
  - Ry [next RA bits]
  - fn [3:0]
  - imm = low DW-2-RA bits, zero-extended to DW.
- Class 00 fn codes:
  - 0 ld, 1 cp, 2 add, 3 sub, 4 inv (two's complement)
  - 5 flp, 6 and, 7 or, 8 xor
  - 9 lsl, A lsr, B asr.
- Class 10 is addi. Class 11 is subi. Class 01, and class 00 with fn C-F, are illegal.
- Reset:
  - State T0; IR, A, G and all registers = 0.
  - done = 0, err = 0, bus_o = 0, ext_ready = 0, instr_ready = 1 on release.
- T0:
  - instr_ready = 1, bus_o = 0.
  - instr_valid & instr_ready latches IR and moves to T1. Otherwise hold.
- ld:
  - T1: ext_ready = 1.
  - Stays in T1 indefinitely while ext_valid = 0.
  - On ext_valid: Rx <= ext_data, then T0.
- cp: T1 Rx <= Ry, then T0. No ALU use.
- inv / flp, single operand, no A step:
  - T1: G <= f(Ry).
  - T2: Rx <= G, then T0.
- Two-operand ops and addi/subi:
  - T1: A <= Rx.
  - T2: G <= A fn (Ry or imm).
  - T3: Rx <= G, then T0.
- Illegal instruction: T1 sets err, no register or A/G write, then T0. err clears only on CLR.
- done: registered, high for exactly one cycle, the cycle after the final write edge (including the illegal case).
- Back-to-back: a new instruction may be accepted in the same T0 cycle in which done is high.
- Arithmetic is modulo 2^DW. Carry and borrow are discarded. Shift amount is the full Ry value:
  - lsl / lsr with amount >= DW gives 0.
  - asr with amount >= DW gives all bits = sign.
- Rx = Ry is legal for all ops. Reads use pre-write values.
- instr and ext_data are ignored outside their ready cycles.
- CLR asserted mid-instruction aborts immediately: full reset values, no partial write.
- timestep equals the state encoding: T0 = 0 .. T3 = 3.

Optional Feature:
BB_STATUS_FLAGS_EN:
- When defined, adds outputs flag_z, flag_n, flag_c (1 bit each).
- Flags update on every G load:
  - z = (G == 0)
  - n = G[DW-1]
  - c = carry-out for add/addi, NOT borrow for sub/subi, 0 otherwise.
- Flags reset to 0.
- When undefined, the ports still exist for interface stability but are tied to 0, and no flag logic is built.

Test Plan:
- ld, DW=10: instr 0x040 (ld R1) with ext_data 0x155, ext_valid = 1 -> R1 = 0x155 via peek; done one cycle after T1; 2 timesteps used.
- add: R1 = 5, R2 = 3, instr 0x062 -> timestep 1,2,3; R1 = 0x008; done once; err = 0.
- subi wrap: R0 = 0, instr 0x301 -> R0 = 0x3FF. With BB_STATUS_FLAGS_EN: n = 1, c = 0.
- asr: R3 = 0x200, R2 = 12, instr 0x0EB -> R3 = 0x3FF. Then lsl R3,R2 -> R3 = 0x000.
- ld stall: ext_valid held low 5 cycles -> timestep stays 1, ext_ready = 1, no done. ext_valid high -> write and done.
- Illegal / reset: instr 0x00C -> err = 1, registers unchanged. Then CLR during T2 of an add -> all registers 0, err = 0, timestep = 0, done = 0.
